// File: rtl/dmem_bus_responder_if.sv
// dmem_bus_responder_if: core data-memory bus, core side is master, RAM responder is slave.
// mem_d_error_o exists only when DMEM_ERROR_EN is defined.
interface dmem_bus_responder_if;
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic [31:0] mem_d_data_rd_o;
`ifdef DMEM_ERROR_EN
    logic        mem_d_error_o;

    modport master (
        output mem_d_addr_i,
        output mem_d_data_wr_i,
        output mem_d_rd_i,
        output mem_d_wr_i,
        input  mem_d_accept_o,
        input  mem_d_ack_o,
        input  mem_d_data_rd_o,
        input  mem_d_error_o
    );

    modport slave (
        input  mem_d_addr_i,
        input  mem_d_data_wr_i,
        input  mem_d_rd_i,
        input  mem_d_wr_i,
        output mem_d_accept_o,
        output mem_d_ack_o,
        output mem_d_data_rd_o,
        output mem_d_error_o
    );
`else
    modport master (
        output mem_d_addr_i,
        output mem_d_data_wr_i,
        output mem_d_rd_i,
        output mem_d_wr_i,
        input  mem_d_accept_o,
        input  mem_d_ack_o,
        input  mem_d_data_rd_o
    );

    modport slave (
        input  mem_d_addr_i,
        input  mem_d_data_wr_i,
        input  mem_d_rd_i,
        input  mem_d_wr_i,
        output mem_d_accept_o,
        output mem_d_ack_o,
        output mem_d_data_rd_o
    );
`endif
endinterface

// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder: word RAM behind the core data bus, in-order acks after LATENCY cycles.
// Define DMEM_ERROR_EN to ack out-of-range addresses with an error instead of aliasing.
module dmem_bus_responder #(
    parameter int unsigned RAM_AW      = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned OUTSTANDING = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    dmem_bus_responder_if.slave bus
);

    localparam int unsigned PW =
        (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned WORDS = 1 << RAM_AW;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [3:0]    tmr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        tmr_t        timer;
    } entry_t;

    logic [31:0] ram [WORDS];
    entry_t      q   [OUTSTANDING];

    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    cnt_t        count;
    logic        ack_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0]       offset;
    logic [RAM_AW-1:0] idx;
    logic              in_range;
    logic              req;
    logic              is_store;
    logic              accept;
    logic              push;
    logic              pop;
    logic              ram_we;
    entry_t            new_entry;
    logic              unused_addr;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign offset = bus.mem_d_addr_i - BASE_ADDR;
    assign idx    = offset[RAM_AW+1:2];

`ifdef DMEM_ERROR_EN
    assign in_range = (offset >> (RAM_AW + 2)) == 32'd0;
`else
    // Without error reporting the upper offset bits simply alias.
    assign in_range = 1'b1;
`endif

    assign unused_addr = ^{offset[1:0], offset[31:RAM_AW+2]};

    assign req      = bus.mem_d_rd_i | (|bus.mem_d_wr_i);
    assign is_store = |bus.mem_d_wr_i;
    assign accept   = rst_i && (count < cnt_t'(OUTSTANDING));
    assign push     = req && accept;
    assign pop      = (count != '0) && (q[rd_ptr].timer == '0);
    assign ram_we   = push && is_store && in_range;

    always_comb begin
        new_entry       = '0;
        new_entry.timer = tmr_t'(LATENCY - 1);
        new_entry.err   = !in_range;
        if (!is_store && in_range) begin
            new_entry.data = ram[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_d_wr_i[b]) begin
                    ram[idx][8*b +: 8] <= bus.mem_d_data_wr_i[8*b +: 8];
                end
            end
        end
    end

    // Entry storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (q[i].timer != '0) begin
                q[i].timer <= q[i].timer - 1'b1;
            end
        end
        if (push) begin
            q[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case (1'b1)
                push && !pop: count <= count + 1'b1;
                pop && !push: count <= count - 1'b1;
                default:      count <= count;
            endcase
            ack_q   <= pop;
            err_q   <= pop && q[rd_ptr].err;
            rdata_q <= pop ? q[rd_ptr].data : '0;
        end
    end

    assign bus.mem_d_accept_o  = accept;
    assign bus.mem_d_ack_o     = ack_q;
    assign bus.mem_d_data_rd_o = rdata_q;

`ifdef DMEM_ERROR_EN
    assign bus.mem_d_error_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_bus_responder.sv
// tb_dmem_bus_responder: directed checks of the data-memory responder.
// A second, slow instance (LATENCY 5, OUTSTANDING 3) reaches the full condition.
`timescale 1ns/1ps
module tb_dmem_bus_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic srst_n;
    int   checks = 0;
    int   failures = 0;

    int          acc_e[$];
    int          ack_e[$];
    logic [31:0] ack_d[$];
    int          issued;
    int          nack;
    int          n;
    logic        take;

    always #5 clk = ~clk;

    dmem_bus_responder_if bus ();
    dmem_bus_responder_if sbus ();

    dmem_bus_responder #(
        .RAM_AW(12), .BASE_ADDR(BASE),
        .LATENCY(2), .OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(bus)
    );

    dmem_bus_responder #(
        .RAM_AW(4), .BASE_ADDR(BASE),
        .LATENCY(5), .OUTSTANDING(3)
    ) u_slow (
        .clk_i(clk), .rst_i(srst_n), .bus(sbus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag,
                        input logic [31:0] addr,
                        input logic [3:0] be,
                        input logic [31:0] wdata,
                        input logic rd,
                        input logic [31:0] exp_data,
                        input logic exp_err);
        int k;
        logic unused_e;
        unused_e = exp_err;
        bus.mem_d_addr_i    = addr;
        bus.mem_d_wr_i      = be;
        bus.mem_d_data_wr_i = wdata;
        bus.mem_d_rd_i      = rd;
        #1;
        k = 0;
        while (bus.mem_d_accept_o !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_acc"}, 32'(bus.mem_d_accept_o), 32'd1);
        tick();
        bus.mem_d_rd_i = 1'b0;
        bus.mem_d_wr_i = 4'h0;
        k = 0;
        while (bus.mem_d_ack_o !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'd2);
        chk({tag, "_data"}, bus.mem_d_data_rd_o, exp_data);
`ifdef DMEM_ERROR_EN
        chk({tag, "_err"}, 32'(bus.mem_d_error_o), 32'(exp_err));
`endif
        tick();
        chk({tag, "_idle_ack"}, 32'(bus.mem_d_ack_o), 32'd0);
        chk({tag, "_idle_dat"}, bus.mem_d_data_rd_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        srst_n = 1'b0;
        bus.mem_d_addr_i     = BASE;
        bus.mem_d_data_wr_i  = '0;
        bus.mem_d_rd_i       = 1'b1;
        bus.mem_d_wr_i       = 4'h0;
        sbus.mem_d_addr_i    = BASE;
        sbus.mem_d_data_wr_i = '0;
        sbus.mem_d_rd_i      = 1'b0;
        sbus.mem_d_wr_i      = 4'h0;

        // 1: reset holds accept and ack low even with a request
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_acc", 32'(bus.mem_d_accept_o), 32'd0);
            chk("rst_ack", 32'(bus.mem_d_ack_o), 32'd0);
            chk("rst_dat", bus.mem_d_data_rd_o, 32'd0);
        end
        bus.mem_d_rd_i = 1'b0;
        rst_n  = 1'b1;
        srst_n = 1'b1;
        #1;
        chk("rel_acc", 32'(bus.mem_d_accept_o), 32'd1);
        chk("rel_sacc", 32'(sbus.mem_d_accept_o), 32'd1);

        // 2: store then load
        xfer("sw", BASE + 32'h10, 4'hF, 32'hDEAD_BEEF,
             1'b0, 32'd0, 1'b0);
        xfer("lw", BASE + 32'h10, 4'h0, 32'd0,
             1'b1, 32'hDEAD_BEEF, 1'b0);

        // 3: byte lanes, and rd with wr acts as a store
        xfer("sw0", BASE + 32'h20, 4'hF, 32'd0,
             1'b0, 32'd0, 1'b0);
        xfer("sb2", BASE + 32'h20, 4'b0100, 32'h55AB_6677,
             1'b0, 32'd0, 1'b0);
        xfer("lb2", BASE + 32'h20, 4'h0, 32'd0,
             1'b1, 32'h00AB_0000, 1'b0);
        xfer("rdwr", BASE + 32'h20, 4'b0001, 32'hFFFF_FF5A,
             1'b1, 32'd0, 1'b0);
        xfer("lrdwr", BASE + 32'h20, 4'h0, 32'd0,
             1'b1, 32'h00AB_005A, 1'b0);

        // 4: six back-to-back loads
        for (int i = 0; i < 6; i++) begin
            xfer("pre", BASE + 32'h100 + 32'(4 * i), 4'hF,
                 32'hA500_0000 + 32'(i), 1'b0, 32'd0, 1'b0);
        end
        issued = 0;
        bus.mem_d_rd_i   = 1'b1;
        bus.mem_d_addr_i = BASE + 32'h100;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (bus.mem_d_ack_o === 1'b1) begin
                ack_e.push_back(c - 1);
                ack_d.push_back(bus.mem_d_data_rd_o);
            end
            take = bus.mem_d_rd_i && bus.mem_d_accept_o;
            tick();
            if (take) begin
                acc_e.push_back(c);
                issued++;
                if (issued < 6) begin
                    bus.mem_d_addr_i = BASE + 32'h100 + 32'(4 * issued);
                end else begin
                    bus.mem_d_rd_i = 1'b0;
                end
            end
        end
        chk("b2b_nacc", 32'(acc_e.size()), 32'd6);
        chk("b2b_nack", 32'(ack_e.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_e.size()) begin
                chk("b2b_acc_edge", 32'(acc_e[i]), 32'(i));
            end
            if (i < ack_e.size()) begin
                chk("b2b_ack_edge", 32'(ack_e[i]), 32'(i + 2));
                chk("b2b_data", ack_d[i], 32'hA500_0000 + 32'(i));
            end
        end

        // 5: reset drops in-flight loads
        bus.mem_d_rd_i   = 1'b1;
        bus.mem_d_addr_i = BASE + 32'h100;
        chk("mid_acc0", 32'(bus.mem_d_accept_o), 32'd1);
        tick();
        bus.mem_d_addr_i = BASE + 32'h104;
        chk("mid_acc1", 32'(bus.mem_d_accept_o), 32'd1);
        tick();
        bus.mem_d_rd_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", 32'(bus.mem_d_accept_o), 32'd0);
        tick();
        rst_n = 1'b1;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_d_ack_o !== 1'b0) nack++;
            tick();
        end
        chk("mid_drop", 32'(nack), 32'd0);
        xfer("post_rst", BASE + 32'h104, 4'h0, 32'd0,
             1'b1, 32'hA500_0001, 1'b0);

        // slow instance: fill to OUTSTANDING, push+pop same edge
        acc_e.delete();
        ack_e.delete();
        ack_d.delete();
        issued = 0;
        sbus.mem_d_wr_i      = 4'hF;
        sbus.mem_d_addr_i    = BASE;
        sbus.mem_d_data_wr_i = 32'd0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (sbus.mem_d_ack_o === 1'b1) begin
                ack_e.push_back(c - 1);
                ack_d.push_back(sbus.mem_d_data_rd_o);
            end
            take = (|sbus.mem_d_wr_i) && sbus.mem_d_accept_o;
            tick();
            if (take) begin
                acc_e.push_back(c);
                issued++;
                if (issued < 5) begin
                    sbus.mem_d_addr_i    = BASE + 32'(4 * issued);
                    sbus.mem_d_data_wr_i = 32'(issued);
                end else begin
                    sbus.mem_d_wr_i = 4'h0;
                end
            end
        end
        chk("full_nacc", 32'(acc_e.size()), 32'd5);
        chk("full_nack", 32'(ack_e.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < acc_e.size()) begin
                chk("full_acc_edge", 32'(acc_e[i]),
                    (i < 3) ? 32'(i) : 32'(i + 3));
            end
            if (i < ack_e.size()) begin
                chk("full_ack_edge", 32'(ack_e[i]),
                    (i < 3) ? 32'(i + 5) : 32'(i + 8));
                chk("full_ack_dat", ack_d[i], 32'd0);
            end
        end

        // slow instance: reset with three stores outstanding
        sbus.mem_d_wr_i   = 4'hF;
        sbus.mem_d_addr_i = BASE;
        for (int i = 0; i < 3; i++) begin
            chk("smid_acc", 32'(sbus.mem_d_accept_o), 32'd1);
            tick();
        end
        sbus.mem_d_wr_i = 4'h0;
        srst_n = 1'b0;
        #1;
        chk("smid_rst_acc", 32'(sbus.mem_d_accept_o), 32'd0);
        tick();
        srst_n = 1'b1;
        nack = 0;
        for (int i = 0; i < 10; i++) begin
            if (sbus.mem_d_ack_o !== 1'b0) nack++;
            tick();
        end
        chk("smid_drop", 32'(nack), 32'd0);
        sbus.mem_d_wr_i = 4'hF;
        chk("spost_acc", 32'(sbus.mem_d_accept_o), 32'd1);
        tick();
        sbus.mem_d_wr_i = 4'h0;
        n = 0;
        while (sbus.mem_d_ack_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("spost_lat", 32'(n), 32'd5);

        // 6: out-of-range addresses
`ifdef DMEM_ERROR_EN
        xfer("e_last", BASE + 32'h3FFC, 4'hF, 32'h0BAD_F00D,
             1'b0, 32'd0, 1'b0);
        xfer("e_ldlast", BASE + 32'h3FFC, 4'h0, 32'd0,
             1'b1, 32'h0BAD_F00D, 1'b0);
        xfer("e_swhi", BASE + 32'h4000, 4'hF, 32'h7777_7777,
             1'b0, 32'd0, 1'b1);
        xfer("e_sw400", BASE + 32'h1000, 4'hF, 32'h1234_5678,
             1'b0, 32'd0, 1'b0);
        xfer("e_swlo", 32'h0000_1000, 4'hF, 32'hCAFE_F00D,
             1'b0, 32'd0, 1'b1);
        xfer("e_ldlo", 32'h0000_1000, 4'h0, 32'd0,
             1'b1, 32'd0, 1'b1);
        xfer("e_ld400", BASE + 32'h1000, 4'h0, 32'd0,
             1'b1, 32'h1234_5678, 1'b0);
`else
        xfer("a_swlo", 32'h0000_1000, 4'hF, 32'hCAFE_F00D,
             1'b0, 32'd0, 1'b0);
        xfer("a_ld400", BASE + 32'h1000, 4'h0, 32'd0,
             1'b1, 32'hCAFE_F00D, 1'b0);
        xfer("a_swhi", BASE + 32'h4000, 4'hF, 32'h7777_7777,
             1'b0, 32'd0, 1'b0);
        xfer("a_ld0", BASE, 4'h0, 32'd0,
             1'b1, 32'h7777_7777, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
